// File: rtl/mem_wb_stage_reg.sv
// MEM/WB pipeline register: valid/ready handshake, flush, optional skid
// entry and a saturating back-pressure counter.
module mem_wb_stage_reg #(
  parameter int DATA_W  = 32,
  parameter int RD_W    = 6,
  parameter int SEL_W   = 2,
  parameter int SKID_EN = 1,
  parameter int CNT_W   = 16
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              FLUSH,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] PCwIMM,
  input  logic [DATA_W-1:0] ALU_res,
  input  logic [DATA_W-1:0] ReadData,
  input  logic [RD_W-1:0]   Rd,
  input  logic              RegWrite,
  input  logic              Z,
  input  logic              N,
  input  logic [SEL_W-1:0]  ThreeWay,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] PCwIMM_out,
  output logic [DATA_W-1:0] ALU_res_out,
  output logic [DATA_W-1:0] ReadData_out,
  output logic [RD_W-1:0]   Rd_out,
  output logic              RegWrite_out,
  output logic              Z_out,
  output logic              N_out,
  output logic [SEL_W-1:0]  ThreeWay_out,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] rdata;
    logic [RD_W-1:0]   rd;
    logic              rw;
    logic              z;
    logic              n;
    logic [SEL_W-1:0]  sel;
  } pl_t;

  pl_t              in_pl;
  pl_t              main_q, main_d;
  pl_t              skid_q, skid_d;
  logic             ov_q, ov_d;
  logic             sv_q, sv_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_xfer;
  logic             out_xfer;
  logic             room;

  if (SKID_EN != 0) begin : g_skid
    assign in_ready = !sv_q;
  end else begin : g_noskid
    assign in_ready = !ov_q | out_ready;
  end

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = ov_q & out_ready;
  assign room     = !ov_q | out_ready;

  always_comb begin
    in_pl  = '{pc: PCwIMM, alu: ALU_res,
               rdata: ReadData, rd: Rd,
               rw: RegWrite, z: Z, n: N,
               sel: ThreeWay};
    main_d = main_q;
    skid_d = skid_q;
    ov_d   = ov_q;
    sv_d   = sv_q;
    cnt_d  = cnt_q;
    // Flush wins over everything; payload fields other than rw may go stale.
    if (FLUSH) begin
      ov_d      = 1'b0;
      sv_d      = 1'b0;
      main_d.rw = 1'b0;
    end else if (sv_q && out_xfer) begin
      main_d = skid_q;
      sv_d   = 1'b0;
      ov_d   = 1'b1;
    end else if (in_xfer && room) begin
      main_d = in_pl;
      ov_d   = 1'b1;
    end else if (in_xfer && SKID_EN != 0) begin
      skid_d = in_pl;
      sv_d   = 1'b1;
    end else if (out_xfer) begin
      ov_d      = 1'b0;
      main_d.rw = 1'b0;
    end
    if (ov_q && !out_ready && cnt_q != '1)
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      main_q <= '0;
      skid_q <= '0;
      ov_q   <= 1'b0;
      sv_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
      ov_q   <= ov_d;
      sv_q   <= sv_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out_valid    = ov_q;
  assign PCwIMM_out   = main_q.pc;
  assign ALU_res_out  = main_q.alu;
  assign ReadData_out = main_q.rdata;
  assign Rd_out       = main_q.rd;
  assign RegWrite_out = main_q.rw;
  assign Z_out        = main_q.z;
  assign N_out        = main_q.n;
  assign ThreeWay_out = main_q.sel;
  assign stall_cnt    = cnt_q;

endmodule

// File: tb/tb_mem_wb_stage_reg.sv
// Directed bench for mem_wb_stage_reg: skid, no-skid and
// narrow-counter instances share one stimulus stream.
module tb_mem_wb_stage_reg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] pc = '0, alu = '0, rdata = '0;
  logic [5:0]  rd = '0;
  logic        rw = 1'b0, z = 1'b0, n = 1'b0;
  logic [1:0]  tw = '0;

  logic        a_ir, a_ov, a_rw, a_z, a_n;
  logic [31:0] a_pc, a_alu, a_rdata;
  logic [5:0]  a_rd;
  logic [1:0]  a_tw;
  logic [15:0] a_cnt;

  logic        b_ir, b_ov, b_rw, b_z, b_n;
  logic [31:0] b_pc, b_alu, b_rdata;
  logic [5:0]  b_rd;
  logic [1:0]  b_tw;
  logic [15:0] b_cnt;

  logic        c_ir, c_ov, c_rw, c_z, c_n;
  logic [31:0] c_pc, c_alu, c_rdata;
  logic [5:0]  c_rd;
  logic [1:0]  c_tw;
  logic [3:0]  c_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_wb_stage_reg u_dut (
    .CLK(clk), .RESET_N(rst_n), .FLUSH(flush),
    .in_valid(in_valid), .in_ready(a_ir),
    .PCwIMM(pc), .ALU_res(alu), .ReadData(rdata),
    .Rd(rd), .RegWrite(rw), .Z(z), .N(n),
    .ThreeWay(tw), .out_valid(a_ov),
    .out_ready(out_ready), .PCwIMM_out(a_pc),
    .ALU_res_out(a_alu), .ReadData_out(a_rdata),
    .Rd_out(a_rd), .RegWrite_out(a_rw),
    .Z_out(a_z), .N_out(a_n), .ThreeWay_out(a_tw),
    .stall_cnt(a_cnt)
  );

  mem_wb_stage_reg #(.SKID_EN(0)) u_ns (
    .CLK(clk), .RESET_N(rst_n), .FLUSH(flush),
    .in_valid(in_valid), .in_ready(b_ir),
    .PCwIMM(pc), .ALU_res(alu), .ReadData(rdata),
    .Rd(rd), .RegWrite(rw), .Z(z), .N(n),
    .ThreeWay(tw), .out_valid(b_ov),
    .out_ready(out_ready), .PCwIMM_out(b_pc),
    .ALU_res_out(b_alu), .ReadData_out(b_rdata),
    .Rd_out(b_rd), .RegWrite_out(b_rw),
    .Z_out(b_z), .N_out(b_n), .ThreeWay_out(b_tw),
    .stall_cnt(b_cnt)
  );

  mem_wb_stage_reg #(.CNT_W(4)) u_sat (
    .CLK(clk), .RESET_N(rst_n), .FLUSH(flush),
    .in_valid(in_valid), .in_ready(c_ir),
    .PCwIMM(pc), .ALU_res(alu), .ReadData(rdata),
    .Rd(rd), .RegWrite(rw), .Z(z), .N(n),
    .ThreeWay(tw), .out_valid(c_ov),
    .out_ready(out_ready), .PCwIMM_out(c_pc),
    .ALU_res_out(c_alu), .ReadData_out(c_rdata),
    .Rd_out(c_rd), .RegWrite_out(c_rw),
    .Z_out(c_z), .N_out(c_n), .ThreeWay_out(c_tw),
    .stall_cnt(c_cnt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
  endtask

  initial begin
    // reset and streaming
    out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) step();
    chk("rst_ov", a_ov, 0);
    chk("rst_alu", a_alu, 0);
    chk("rst_rw", a_rw, 0);
    chk("rst_ir", a_ir, 1);
    chk("rst_cnt", a_cnt, 0);
    rst_n = 1'b1;
    #1;
    chk("rel_ir", a_ir, 1);
    in_valid = 1'b1;
    rw = 1'b1;
    z = 1'b1;
    tw = 2'd2;
    for (int i = 1; i <= 4; i++) begin
      alu = 32'(i);
      rd = 6'(i + 8);
      step();
      chk($sformatf("str_alu%0d", i), a_alu, i);
      chk($sformatf("str_ov%0d", i), a_ov, 1);
      chk($sformatf("str_rd%0d", i), a_rd, i + 8);
    end
    chk("str_z", a_z, 1);
    chk("str_tw", a_tw, 2);
    in_valid = 1'b0;
    step();
    chk("drain_ov", a_ov, 0);
    chk("drain_rw", a_rw, 0);
    chk("str_cnt", a_cnt, 0);

    // back-pressure with skid
    out_ready = 1'b0;
    in_valid = 1'b1;
    alu = 32'hA;
    step();
    chk("bp_A", a_alu, 32'hA);
    chk("bp_ir0", a_ir, 1);
    alu = 32'hB;
    step();
    chk("bp_holdA", a_alu, 32'hA);
    chk("bp_ir1", a_ir, 0);
    alu = 32'hC;
    step();
    chk("bp_holdA2", a_alu, 32'hA);
    chk("bp_ir2", a_ir, 0);
    step();
    chk("bp_cnt", a_cnt, 3);
    out_ready = 1'b1;
    step();
    chk("bp_B", a_alu, 32'hB);
    chk("bp_ir3", a_ir, 1);
    step();
    chk("bp_C", a_alu, 32'hC);
    in_valid = 1'b0;
    step();
    chk("bp_empty", a_ov, 0);
    chk("bp_cnt2", a_cnt, 3);

    // flush during stall
    out_ready = 1'b0;
    in_valid = 1'b1;
    rw = 1'b1;
    alu = 32'h11;
    step();
    chk("fl_main", a_alu, 32'h11);
    chk("fl_rw", a_rw, 1);
    alu = 32'h22;
    step();
    chk("fl_skid_ir", a_ir, 0);
    flush = 1'b1;
    alu = 32'h33;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_ov", a_ov, 0);
    chk("fl_rw0", a_rw, 0);
    chk("fl_ir", a_ir, 1);
    chk("fl_cnt_kept", a_cnt, 5);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("fl_bubble%0d", i), a_ov, 0);
    end

    // no-skid variant
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1;
    alu = 32'h41;
    step();
    chk("ns_main", b_alu, 32'h41);
    chk("ns_ov", b_ov, 1);
    alu = 32'h42;
    #1;
    chk("ns_ir0", b_ir, 0);
    step();
    chk("ns_hold", b_alu, 32'h41);
    out_ready = 1'b1;
    #1;
    chk("ns_ir1", b_ir, 1);
    step();
    chk("ns_42", b_alu, 32'h42);
    chk("ns_ov2", b_ov, 1);
    alu = 32'h43;
    step();
    chk("ns_43", b_alu, 32'h43);
    in_valid = 1'b0;
    step();
    chk("ns_empty", b_ov, 0);

    // counter saturation, skid filled for the async reset test
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1;
    alu = 32'h51;
    step();
    chk("sat_cnt0", c_cnt, 0);
    alu = 32'h52;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 15) chk("sat_15", c_cnt, 15);
    end
    chk("sat_hold", c_cnt, 15);
    chk("wide_cnt", a_cnt, 20);
    chk("sat_skid", a_ir, 0);
    chk("sat_ov", a_ov, 1);

    // asynchronous reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_ov", a_ov, 0);
    chk("ar_ir", a_ir, 1);
    chk("ar_cnt", a_cnt, 0);
    chk("ar_alu", a_alu, 0);
    chk("ar_sat_cnt", c_cnt, 0);
    rst_n = 1'b1;
    in_valid = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage_reg.md
Name: mem_wb_stage_reg

Overview:
- Parametrised MEM/WB pipeline stage register with a valid/ready handshake, synchronous flush, an optional skid buffer and a saturating stall counter.
- Sits between data-memory access and register-file write-back.
- Carries the stage payload: PC+imm, ALU result, load data, destination register, RegWrite, 3-way WB select, Z/N flags.
- Allows write-back to back-pressure the stage without a combinational ready path when the skid is enabled.

Parameters:
- DATA_W, 32, width of PCwIMM, ALU_res, ReadData.
- RD_W, 6, destination register index width.
- SEL_W, 2, write-back select (ThreeWay) width.
- SKID_EN, 1, 1 = two-entry (main + skid), registered in_ready; 0 = single entry, combinational in_ready.
- CNT_W, 16, stall counter width.

Ports:
- CLK  in  1  clock, rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- FLUSH  in  1  synchronous squash of all held entries.
- in_valid  in  1  MEM stage presents a valid payload.
- in_ready  out  1  stage can accept this cycle.
- PCwIMM, ALU_res, ReadData  in  DATA_W each  payload.
- Rd  in  RD_W  destination register.
- RegWrite, Z, N  in  1 each  payload.
- ThreeWay  in  SEL_W  WB select.
- out_valid  out  1  output payload valid.
- out_ready  in  1  WB stage consumes this cycle.
- PCwIMM_out, ALU_res_out, ReadData_out, Rd_out, RegWrite_out, Z_out, N_out, ThreeWay_out  out  matching widths  registered payload.
- stall_cnt  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

Behaviour:
- Reset (RESET_N=0, asynchronous):
  - All payload outputs, out_valid, skid contents and skid valid are cleared to 0; stall_cnt = 0.
  - in_ready = 1 while in reset and on the first cycle after release.
- Transfers:
  - Input transfer = in_valid & in_ready at a rising edge.
  - Output transfer = out_valid & out_ready at a rising edge.
  - Latency is one cycle: a payload accepted at edge k appears on the outputs after edge k when the main register is empty or draining.
- SKID_EN=1:
  - in_ready = !skid_valid (registered).
  - Main full, not draining, input transfer: payload goes to skid; skid_valid=1.
  - Main draining with skid_valid=1: skid moves to main; skid_valid=0. A simultaneous input transfer is impossible because in_ready=0.
  - Main draining or empty, skid empty, input transfer: payload loads main.
  - Ordering is strictly FIFO; no payload is dropped or duplicated.
- SKID_EN=0:
  - in_ready = !out_valid | out_ready (combinational).
  - Main loads on every input transfer.
- out_valid=0, no input transfer: main holds its contents; out_valid stays 0.
- RegWrite_out is 0 whenever out_valid=0 (cleared on drain-without-refill and on flush). WB never writes the register file from a bubble.
- FLUSH=1 at an edge:
  - out_valid, skid_valid and RegWrite_out are cleared.
  - Flush overrides a same-cycle input transfer; the incoming payload is discarded.
  - Other payload fields may hold stale values.
  - in_ready = 1 on the following cycle.
- stall_cnt:
  - Increments by 1 at each edge where out_valid=1 and out_ready=0.
  - Saturates at 2^CNT_W-1.
  - Cleared only by reset; flush does not clear it.
- Reset asserted mid-transfer: all state clears immediately and the in-flight payload is lost.
- Z/N and ThreeWay are passed through unmodified; no arithmetic is performed in this block.

Test Plan:
- Reset and stream: RESET_N low 3 cycles then high; stream ALU_res=1..4 with in_valid=1 and out_ready=1 -> outputs are 0 during reset; ALU_res_out=1,2,3,4 on consecutive cycles, one cycle after each input; out_valid continuous; stall_cnt=0.
- Back-pressure (SKID_EN=1): out_ready=0 for 3 cycles while sending A=0xA, B=0xB, C=0xC -> A held on outputs, B captured in skid, in_ready=0 after B, C held upstream. Release gives order A,B,C. stall_cnt=3.
- Flush during stall: main=0x11 with RegWrite=1, skid=0x22; assert FLUSH with in_valid=1 (0x33) -> next cycle out_valid=0, RegWrite_out=0, in_ready=1; 0x33 never appears at the output.
- SKID_EN=0 variant: out_ready=0 with out_valid=1 -> in_ready=0 in the same cycle; asserting out_ready=1 raises in_ready combinationally, giving a back-to-back transfer with no bubble.
- Counter saturation, CNT_W=4: hold the stall for 20 cycles -> stall_cnt reaches 15 and stays at 15.
- Asynchronous reset mid-operation: pulse RESET_N low between clock edges while out_valid=1 and skid full -> out_valid, skid and stall_cnt go to 0 without waiting for a clock edge.
